serial_half_add_acc: RTL and testbench



---
 rtl/serial_half_add_acc_if.sv | 26 ++
 rtl/serial_half_add_acc.sv | 92 +++++++++
 tb/tb_serial_half_add_acc.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/serial_half_add_acc_if.sv
// Handshake and result bundle for the bit-serial adder/accumulator.
// The master modport is the producer of bit pairs and the consumer of the result.
interface serial_half_add_acc_if #(
  parameter int unsigned WIDTH = 8
);
  logic             START;
  logic             VALID;
  logic             A;
  logic             B;
  logic             ACK;
  logic             READY;
  logic [WIDTH-1:0] SUM;
  logic             COUT;
  logic             DONE;
  logic             BUSY;

  modport master (
    output START, VALID, A, B, ACK,
    input  READY, SUM, COUT, DONE, BUSY
  );

  modport slave (
    input  START, VALID, A, B, ACK,
    output READY, SUM, COUT, DONE, BUSY
  );
endinterface

// File: rtl/serial_half_add_acc.sv
// Bit-serial adder/accumulator: one A/B bit pair per accepted cycle, LSB first,
// half-adder pair plus registered carry, result held with a DONE/ACK handshake.
module serial_half_add_acc #(
  parameter int unsigned WIDTH = 8
) (
  input logic                  CLK,
  input logic                  RST,
  serial_half_add_acc_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   count_q, count_d;

  // Two cascaded half adders: (A,B) then (partial sum, carry).
  logic hs_ab, hc_ab, bit_sum, hc_cin, carry_nxt;

  always_comb begin
    hs_ab     = bus.A ^ bus.B;
    hc_ab     = bus.A & bus.B;
    bit_sum   = hs_ab ^ carry_q;
    hc_cin    = hs_ab & carry_q;
    carry_nxt = hc_ab | hc_cin;
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    carry_d = carry_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (bus.START) begin
          state_d = StRun;
          sum_d   = '0;
          cout_d  = 1'b0;
          carry_d = 1'b0;
          count_d = '0;
        end
      end
      StRun: begin
        // A/B are only looked at when VALID is high, so X in gaps never lands in state.
        if (bus.VALID) begin
          sum_d   = {bit_sum, sum_q[WIDTH-1:1]};
          carry_d = carry_nxt;
          count_d = count_q + 1'b1;
          if (count_q == LastBit) begin
            cout_d  = carry_nxt;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (bus.ACK) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      carry_q <= carry_d;
      count_q <= count_d;
    end
  end

  assign bus.READY = (state_q == StRun);
  assign bus.DONE  = (state_q == StDone);
  assign bus.BUSY  = (state_q != StIdle);
  assign bus.SUM   = sum_q;
  assign bus.COUT  = cout_q;

endmodule

// File: tb/tb_serial_half_add_acc.sv
// Self-checking bench for serial_half_add_acc: directed cases plus random
// operands and gaps, checked against plain (a + b) arithmetic.
module tb_serial_half_add_acc;

  localparam int unsigned W = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   gap_before [W];
  logic [W-1:0] exp_sum;
  logic         exp_cout;

  serial_half_add_acc_if #(.WIDTH(W)) bus ();

  serial_half_add_acc #(.WIDTH(W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_gaps();
    for (int i = 0; i < W; i++) gap_before[i] = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(bus.READY), 64'd0);
    check({tag, "_done"},  64'(bus.DONE),  64'd0);
    check({tag, "_busy"},  64'(bus.BUSY),  64'd0);
    check({tag, "_sum"},   64'(bus.SUM),   64'd0);
    check({tag, "_cout"},  64'(bus.COUT),  64'd0);
  endtask

  // Start an addition and stream W bits, LSB first; stops with the block in DONE.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int start_bit);
    logic [W:0] full;
    full     = {1'b0, a} + {1'b0, b};
    exp_sum  = full[W-1:0];
    exp_cout = full[W];
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    check("run_ready", 64'(bus.READY), 64'd1);
    check("run_busy",  64'(bus.BUSY),  64'd1);
    for (int i = 0; i < W; i++) begin
      for (int g = 0; g < gap_before[i]; g++) begin
        bus.VALID = 1'b0;
        bus.A     = 1'bx;
        bus.B     = 1'bx;
        tick();
        check("gap_ready", 64'(bus.READY), 64'd1);
      end
      bus.VALID = 1'b1;
      bus.A     = a[i];
      bus.B     = b[i];
      bus.START = (i == start_bit);
      tick();
      bus.VALID = 1'b0;
      bus.START = 1'b0;
      if (i < W - 1) check("done_early", 64'(bus.DONE), 64'd0);
      else           check("done_rise",  64'(bus.DONE), 64'd1);
    end
    check("res_sum",   64'(bus.SUM),   64'(exp_sum));
    check("res_cout",  64'(bus.COUT),  64'(exp_cout));
    check("res_busy",  64'(bus.BUSY),  64'd1);
    check("res_ready", 64'(bus.READY), 64'd0);
  endtask

  // Hold in DONE with junk on the other inputs, then acknowledge.
  task automatic ack_done(input int hold);
    for (int h = 0; h < hold; h++) begin
      bus.VALID = 1'b1;
      bus.A     = 1'($urandom);
      bus.B     = 1'($urandom);
      bus.START = 1'($urandom);
      tick();
      check("hold_done", 64'(bus.DONE), 64'd1);
      check("hold_sum",  64'(bus.SUM),  64'(exp_sum));
      check("hold_cout", 64'(bus.COUT), 64'(exp_cout));
    end
    bus.VALID = 1'b0;
    bus.START = 1'b0;
    bus.ACK   = 1'b1;
    tick();
    bus.ACK = 1'b0;
    check("ack_done", 64'(bus.DONE), 64'd0);
    check("ack_busy", 64'(bus.BUSY), 64'd0);
    check("idle_sum", 64'(bus.SUM),  64'(exp_sum));
    check("idle_cout", 64'(bus.COUT), 64'(exp_cout));
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    bus.START = 1'b0;
    bus.VALID = 1'b0;
    bus.A     = 1'b0;
    bus.B     = 1'b0;
    bus.ACK   = 1'b0;
    clear_gaps();
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    do_op(8'h5A, 8'h3C, -1);
    ack_done(1);
    do_op(8'hFF, 8'h01, -1);
    ack_done(0);
    do_op(8'h80, 8'h80, -1);
    ack_done(0);
    do_op(8'h00, 8'h00, -1);
    ack_done(0);

    gap_before[3] = 3;
    gap_before[6] = 1;
    do_op(8'h12, 8'h34, -1);
    ack_done(0);
    clear_gaps();

    do_op(8'hAA, 8'h55, 4);
    ack_done(10);

    // Reset mid-RUN discards the partial result.
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.VALID = 1'b1;
      bus.A     = 1'((8'hF0 >> i) & 8'h01);
      bus.B     = 1'((8'h0F >> i) & 8'h01);
      tick();
    end
    bus.VALID = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("rst_run");
    do_op(8'h01, 8'h01, -1);
    ack_done(0);

    // Reset wins over ACK in DONE, and over START in IDLE.
    do_op(8'hC3, 8'h7E, -1);
    rst     = 1'b1;
    bus.ACK = 1'b1;
    tick();
    bus.ACK = 1'b0;
    check_reset_outputs("rst_ack");
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    rst = 1'b0;
    check_reset_outputs("rst_start");
    tick();
    check("idle_stay", 64'(bus.BUSY), 64'd0);

    for (int r = 0; r < 20; r++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      for (int i = 0; i < W; i++) gap_before[i] = ($urandom_range(3) == 0) ? $urandom_range(3) : 0;
      do_op(ra, rb, ($urandom_range(1) == 0) ? int'($urandom_range(W - 1)) : -1);
      ack_done(int'($urandom_range(3)));
    end
    clear_gaps();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
